// File: rtl/nw_chunk_scheduler.sv
// Walks an N x N Needleman-Wunsch matrix one L x L Grid chunk at a time,
// feeding boundary scores in and buffering the bottom/right results.
module nw_chunk_scheduler #(
    parameter int CHUNK_LENGTH = 10,
    parameter int MAX_CHUNKS   = 8,
    parameter int SWIDTH       = 16,
    parameter int CNT_WIDTH    = 8,
    parameter int INDEL        = -1,
    parameter int GRID_LAT     = 20
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [CNT_WIDTH-1:0]                  n_chunks,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error,
    output logic [SWIDTH-1:0]                     final_score,
    output logic [CNT_WIDTH-1:0]                  chunk_row,
    output logic [CNT_WIDTH-1:0]                  chunk_col,
    output logic                                  grid_valid,
    output logic [(CHUNK_LENGTH+1)*SWIDTH-1:0]    top_scores,
    output logic [CHUNK_LENGTH*SWIDTH-1:0]        left_scores,
    input  logic [CHUNK_LENGTH*SWIDTH-1:0]        bottom_scores,
    input  logic [CHUNK_LENGTH*SWIDTH-1:0]        right_scores
);

    localparam int L     = CHUNK_LENGTH;
    localparam int DEPTH = MAX_CHUNKS * L;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW    = (GRID_LAT > 1) ? $clog2(GRID_LAT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [LW-1:0]              lat_cnt;
    logic [CNT_WIDTH-1:0]       n_q;
    logic [CNT_WIDTH-1:0]       r_nx;
    logic [CNT_WIDTH-1:0]       c_nx;
    logic [SWIDTH-1:0]          rowbuf [DEPTH];
    logic [(L+1)*SWIDTH-1:0]    top_nx;
    logic [L*SWIDTH-1:0]        left_nx;
    logic [AW-1:0]              wbase;
    logic                       legal;
    logic                       accept;
    logic                       last;
    logic                       wait_end;

    assign legal    = (n_chunks != '0) &&
                      (n_chunks <= CNT_WIDTH'(MAX_CHUNKS));
    assign accept   = (state == S_IDLE) && start && legal;
    assign last     = (chunk_row == n_q - 1'b1) &&
                      (chunk_col == n_q - 1'b1);
    assign wait_end = (lat_cnt == LW'(GRID_LAT - 1));
    assign wbase    = AW'(int'(chunk_col) * L);

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign grid_valid = (state == S_LOAD);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (accept) state_n = S_LOAD;
            S_LOAD:  state_n = S_WAIT;
            S_WAIT:  if (wait_end) state_n = S_STORE;
            S_STORE: state_n = last ? S_DONE : S_LOAD;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        r_nx = '0;
        c_nx = '0;
        if (state == S_STORE) begin
            if (chunk_col == n_q - 1'b1) begin
                r_nx = chunk_row + 1'b1;
            end else begin
                r_nx = chunk_row;
                c_nx = chunk_col + 1'b1;
            end
        end
    end

    // Boundaries for the chunk about to be loaded. rowbuf still holds its
    // pre-STORE contents here, so rowbuf[H'-1] is the corner for (r,c+1).
    always_comb begin
        int g;
        int h;
        logic [AW-1:0] idx;
        g       = int'(r_nx) * L;
        h       = int'(c_nx) * L;
        idx     = '0;
        top_nx  = '0;
        left_nx = '0;
        for (int k = 0; k <= L; k++) begin
            if (r_nx == '0) begin
                top_nx[k*SWIDTH +: SWIDTH] = SWIDTH'((h + k) * INDEL);
            end else if (k == 0 && c_nx == '0) begin
                top_nx[k*SWIDTH +: SWIDTH] = SWIDTH'(g * INDEL);
            end else begin
                idx = AW'(h + k - 1);
                top_nx[k*SWIDTH +: SWIDTH] = rowbuf[idx];
            end
        end
        for (int k = 0; k < L; k++) begin
            if (c_nx == '0)
                left_nx[k*SWIDTH +: SWIDTH] = SWIDTH'((g + k + 1) * INDEL);
            else
                left_nx[k*SWIDTH +: SWIDTH] = right_scores[k*SWIDTH +: SWIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            error       <= 1'b0;
            n_q         <= '0;
            chunk_row   <= '0;
            chunk_col   <= '0;
            final_score <= '0;
            top_scores  <= '0;
            left_scores <= '0;
            lat_cnt     <= '0;
        end else begin
            error   <= (state == S_IDLE) && start && !legal;
            lat_cnt <= (state == S_WAIT) ? lat_cnt + 1'b1 : '0;
            if (accept) begin
                n_q         <= n_chunks;
                final_score <= '0;
            end
            if (accept || (state == S_STORE && !last)) begin
                chunk_row   <= r_nx;
                chunk_col   <= c_nx;
                top_scores  <= top_nx;
                left_scores <= left_nx;
            end
            if (state == S_STORE && last)
                final_score <= bottom_scores[(L-1)*SWIDTH +: SWIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_STORE) begin
            for (int k = 0; k < L; k++)
                rowbuf[wbase + AW'(k)] <= bottom_scores[k*SWIDTH +: SWIDTH];
        end
    end

endmodule
